// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate at tail, out-of-order CDB completion, in-order retire at head.
// Also provides a combinational operand lookup with CDB forwarding for dispatch.
module rob_commit #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_ready,
  output logic [DATA_W-1:0] lookup_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(DEPTH);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  done_q;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;
  logic [TAG_W:0]    count_d;

  logic              commit_valid_q;
  logic [REG_W-1:0]  commit_dest_q;
  logic [DATA_W-1:0] commit_data_q;

  logic fire;
  logic retire;
  logic cdb_wr;

  // No same-cycle bypass: a retiring slot is only offered the following cycle.
  assign alloc_ready = (count_q < FullCount);
  assign alloc_tag   = tail_q;
  assign fire        = alloc_valid && alloc_ready;
  assign retire      = busy_q[head_q] && done_q[head_q];
  assign cdb_wr      = cdb_valid && busy_q[cdb_tag] && !done_q[cdb_tag];

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_data  = commit_data_q;

  always_comb begin
    count_d = count_q;
    if (fire && !retire) begin
      count_d = count_q + 1'b1;
    end else if (retire && !fire) begin
      count_d = count_q - 1'b1;
    end
  end

  // Allocation, writeback and retire never touch the same slot in one cycle:
  // the tail slot is free when allocating, and the head slot is already done when retiring.
  always_ff @(posedge clk1) begin
    if (rst) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
    end else begin
      if (fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;
      end
      if (cdb_wr) begin
        done_q[cdb_tag] <= 1'b1;
      end
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
        commit_dest_q  <= dest_q[head_q];
        commit_data_q  <= data_q[head_q];
      end
      // arf[0] is hardwired zero, so a dest-0 retire produces no write pulse.
      commit_valid_q <= retire && (dest_q[head_q] != '0);
      count_q        <= count_d;
    end
  end

  // Payload storage needs no reset; busy/done qualify every use.
  always_ff @(posedge clk1) begin
    if (!rst && fire) begin
      dest_q[tail_q] <= alloc_dest;
    end
    if (!rst && cdb_wr) begin
      data_q[cdb_tag] <= cdb_data;
    end
  end

  always_comb begin
    lookup_ready = 1'b0;
    lookup_data  = '0;
    if (busy_q[lookup_tag]) begin
      if (done_q[lookup_tag]) begin
        lookup_ready = 1'b1;
        lookup_data  = data_q[lookup_tag];
      end else begin
        lookup_ready = cdb_valid && (cdb_tag == lookup_tag);
        lookup_data  = cdb_data;
      end
    end
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- 8-entry reorder buffer for the Tomasulo core.
- Dispatch allocates entries in program order at the tail and receives an entry tag.
- Execution units write results to an entry by tag over the CDB.
- Completed entries retire strictly in order from the head and write the architectural register file (arf).
- The block also gives dispatch a tag-lookup port so it can forward operands from in-flight results.

Parameters:
- DEPTH, 8, number of ROB entries; must be a power of two.
- TAG_W, 3, log2(DEPTH); width of tags, head and tail.
- DATA_W, 32, result/data width.
- REG_W, 4, arf index width (arf[0..10] used; arf[0] is hardwired zero).

Ports:
- clk1  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatch requests a new entry.
- alloc_dest  in  REG_W  destination arf index of the dispatched instruction.
- alloc_ready  out  1  entry available: high when count < DEPTH (combinational from registered count).
- alloc_tag  out  TAG_W  tag granted; equals tail (combinational).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  ROB tag of the broadcast result.
- cdb_data  in  DATA_W  broadcast result value.
- lookup_tag  in  TAG_W  operand tag queried by dispatch.
- lookup_ready  out  1  queried entry's value is available (combinational).
- lookup_data  out  DATA_W  queried value (combinational).
- commit_valid  out  1  registered one-cycle pulse: write arf[commit_dest].
- commit_dest  out  REG_W  registered arf index.
- commit_data  out  DATA_W  registered value.
- count  out  TAG_W+1  registered number of busy entries.
- empty  out  1  count == 0.

Behaviour:
- Per-entry state: busy, done, dest, data. Registered pointers: head, tail, count.
- Reset (rst high at posedge):
  - all busy and done cleared; head = tail = 0; count = 0.
  - commit_valid = 0; commit_dest = 0; commit_data = 0.
  - Result: alloc_ready = 1, alloc_tag = 0, empty = 1, lookup_ready = 0.
  - Reset mid-operation discards all in-flight entries. No commit pulse occurs in the reset cycle.
- Allocation (fire = alloc_valid && alloc_ready):
  - entry[tail] gets busy = 1, done = 0, dest = alloc_dest.
  - tail increments mod DEPTH (7 wraps to 0).
  - alloc_valid while full is ignored; no state change.
- CDB writeback:
  - If cdb_valid && entry[cdb_tag].busy && !done: set done = 1 and data = cdb_data.
  - A broadcast to a non-busy or already-done entry is ignored.
  - One broadcast per cycle.
- Commit (retire = entry[head].busy && entry[head].done, evaluated on registered state):
  - On retire: clear entry[head].busy and done; head increments mod DEPTH.
  - commit_valid = 1 next cycle, with commit_dest and commit_data taken from the entry.
  - An entry with dest == 0 retires normally but commit_valid stays 0 (arf[0] is never written).
  - commit_valid is 0 in every cycle without a retire; commit_dest and commit_data hold their last values.
  - At most one retire per cycle.
- Latency:
  - A CDB write at cycle N makes done visible at N+1.
  - If that entry is at the head, it retires at N+1 and commit_valid is high during N+2.
  - Minimum latency from allocation to commit pulse is 3 cycles (alloc N, CDB N+1, pulse N+3).
- count update: count_next = count + fire − retire. Simultaneous alloc and retire leaves count unchanged.
- Full (count == DEPTH): alloc_ready = 0 even if a retire happens in the same cycle. There is no same-cycle bypass; the freed slot is offered next cycle.
- Lookup:
  - lookup_ready = entry.busy && (entry.done || (cdb_valid && cdb_tag == lookup_tag)).
  - lookup_data = entry data if done, otherwise cdb_data (CDB forwarding).
  - If the entry is not busy, lookup_ready = 0 and lookup_data = 0.
- Results may arrive out of order. A younger done entry waits until every older entry has retired.

Test Plan:
1. Reset, then allocate dest=3 (tag 0); CDB tag0 = 45 next cycle -> commit_valid pulses two cycles after the CDB with dest=3, data=45; count returns to 0; empty = 1.
2. Allocate tags 0,1,2 (dests 1,2,4); CDB order 2 (=5), 1 (=16), 0 (=12) -> commits in order dest1=12, dest2=16, dest4=5 on consecutive cycles after tag0 completes.
3. Allocate 8 entries -> alloc_ready = 0, count = 8; 9th alloc_valid ignored. Complete the head -> it retires; alloc_ready = 1 the next cycle; the next alloc gets tag 0 (wrap).
4. Full ROB with head retiring and alloc_valid high in the same cycle -> no allocation that cycle; count = 7 next cycle; allocation accepted the cycle after.
5. Entry tag 5 busy, not done: lookup_tag = 5 with same-cycle CDB tag5 = 99 -> lookup_ready = 1, lookup_data = 99. Next cycle, without CDB -> still 1/99. Lookup of a free tag -> 0/0.
6. Allocate dest=0, CDB = 7 -> the entry retires (head advances, count decrements) with no commit_valid pulse. Then assert rst with 3 busy entries -> all cleared, count = 0, no pulse.
